shift_add_mul_ctrl: RTL and testbench



---
 rtl/shift_add_mul_ctrl_pkg.sv | 13 +
 rtl/shift_add_mul_ctrl_mul_shift_stage.sv | 25 ++
 rtl/shift_add_mul_ctrl.sv | 106 ++++++++++
 tb/tb_shift_add_mul_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_mul_ctrl_pkg.sv
// rtl/shift_add_mul_ctrl_pkg.sv - shared FSM encoding and count-width helper for the shift-add multiplier
package shift_add_mul_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bits needed to hold a bit index 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_add_mul_ctrl_mul_shift_stage.sv
// rtl/shift_add_mul_ctrl_mul_shift_stage.sv - per-cycle partial product: shifted multiplicand, optionally negated
module mul_shift_stage #(
  parameter int N  = 8,
  parameter int CW = 3
) (
  input  logic [2*N-1:0] a_reg,
  input  logic [CW-1:0]  cnt,
  input  logic           b_bit,
  input  logic           sub,
  output logic [2*N-1:0] addend
);

  logic [2*N-1:0] shifted;

  assign shifted = a_reg << cnt;

  // Zero when the multiplier bit is clear; the two's-complement MSB weight is negative, so negate it.
  always_comb begin
    addend = '0;
    if (b_bit) begin
      addend = sub ? -shifted : shifted;
    end
  end

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// rtl/shift_add_mul_ctrl.sv - radix-2 shift-and-add multiplier with valid/ready operand and product ports
module shift_add_mul_ctrl
  import shift_add_mul_ctrl_pkg::*;
#(
  parameter int N      = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           abort,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p,
  output logic           busy
);

  localparam int            CW       = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]     state;
  logic [2*N-1:0] a_reg;
  logic [N-1:0]   b_reg;
  logic [2*N-1:0] acc;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] p_reg;

  logic [2*N-1:0] a_ext;
  logic [2*N-1:0] addend;
  logic [2*N-1:0] acc_next;
  logic           sub;
  logic           last_bit;

  assign a_ext    = SIGNED ? {{N{a[N-1]}}, a} : {{N{1'b0}}, a};
  assign last_bit = (cnt == CNT_LAST);
  assign sub      = SIGNED && last_bit;
  assign acc_next = acc + addend;

  mul_shift_stage #(
    .N  (N),
    .CW (CW)
  ) u_stage (
    .a_reg  (a_reg),
    .cnt    (cnt),
    .b_bit  (b_reg[cnt]),
    .sub    (sub),
    .addend (addend)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_RUN) || (state == ST_DONE);
  assign p         = p_reg;

  // Control FSM: capture operands, walk one multiplier bit per cycle, hold the product until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      p_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && !abort) begin
            a_reg <= a_ext;
            b_reg <= b;
            acc   <= '0;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            acc   <= '0;
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            acc <= acc_next;
            cnt <= cnt + CNT_ONE;
            if (last_bit) begin
              p_reg <= acc_next;
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (abort) begin
            acc   <= '0;
            state <= ST_IDLE;
          end else if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// tb/tb_shift_add_mul_ctrl.sv - self-checking bench for shift_add_mul_ctrl, unsigned and signed instances
module tb_shift_add_mul_ctrl;

  localparam int N = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          abort;
  logic          out_ready;

  logic          ir_u, ov_u, busy_u;
  logic [2*N-1:0] p_u;
  logic          ir_s, ov_s, busy_s;
  logic [2*N-1:0] p_s;

  int checks = 0;
  int errors = 0;

  shift_add_mul_ctrl #(.N(N), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_u),
    .a(a), .b(b), .abort(abort), .out_valid(ov_u), .out_ready(out_ready),
    .p(p_u), .busy(busy_u)
  );

  shift_add_mul_ctrl #(.N(N), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_s),
    .a(a), .b(b), .abort(abort), .out_valid(ov_s), .out_ready(out_ready),
    .p(p_s), .busy(busy_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2*N-1:0] prod_u(input logic [N-1:0] x, input logic [N-1:0] y);
    int r;
    r = int'(x) * int'(y);
    return r[2*N-1:0];
  endfunction

  function automatic logic [2*N-1:0] prod_s(input logic [N-1:0] x, input logic [N-1:0] y);
    int r;
    r = int'($signed(x)) * int'($signed(y));
    return r[2*N-1:0];
  endfunction

  // Reference model: one outstanding op, result due N+1 cycles after the accept cycle.
  bit             pending = 1'b0;
  int             age = 0;
  bit             exp_ov;
  logic [2*N-1:0] exp_u, exp_s;
  logic [2*N-1:0] last_u = '0;
  logic [2*N-1:0] last_s = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 1'b0;
      age     = 0;
      last_u  = '0;
      last_s  = '0;
    end else begin
      if (pending) age++;
      exp_ov = pending && (age >= N + 1);
      if (exp_ov) begin
        last_u = exp_u;
        last_s = exp_s;
      end
      chk("model in_ready_u",  ir_u,   !pending);
      chk("model in_ready_s",  ir_s,   !pending);
      chk("model busy_u",      busy_u, pending);
      chk("model busy_s",      busy_s, pending);
      chk("model out_valid_u", ov_u,   exp_ov);
      chk("model out_valid_s", ov_s,   exp_ov);
      chk("model p_u",         p_u,    last_u);
      chk("model p_s",         p_s,    last_s);
      if (pending && abort) begin
        pending = 1'b0;
      end else if (exp_ov && out_ready) begin
        pending = 1'b0;
      end else if (!pending && in_valid && !abort) begin
        pending = 1'b1;
        age     = 0;
        exp_u   = prod_u(a, b);
        exp_s   = prod_s(a, b);
      end
    end
  end

  // Caller must be just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv);
    int t;
    t = 0;
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(negedge clk);
    while (!ir_u && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (t >= 64) chk("accept timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ov_u && cyc < 64);
    if (cyc >= 64) chk("out_valid timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input logic [N-1:0] av, input logic [N-1:0] bv,
                       input logic [2*N-1:0] eu, input logic [2*N-1:0] es, input string nm);
    int cyc;
    send(av, bv);
    wait_out(cyc);
    chk({nm, " latency"}, cyc, N + 1);
    chk({nm, " p_u"}, p_u, eu);
    chk({nm, " p_s"}, p_s, es);
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0]   va [7]  = '{8'd13, 8'd255, 8'd0,   8'd1,   8'h80, 8'hFF, 8'd127};
  logic [N-1:0]   vb [7]  = '{8'd11, 8'd255, 8'd200, 8'd128, 8'h80, 8'd127, 8'hFF};
  logic [2*N-1:0] veu [7] = '{16'h008F, 16'hFE01, 16'h0000, 16'h0080, 16'h4000, 16'h7E81, 16'h7E81};
  logic [2*N-1:0] ves [7] = '{16'h008F, 16'h0001, 16'h0000, 16'hFF80, 16'h4000, 16'hFF81, 16'hFF81};

  initial begin
    int cyc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    abort     = 1'b0;
    out_ready = 1'b1;

    #3;
    chk("reset in_ready",  ir_u,   1'b1);
    chk("reset out_valid", ov_u,   1'b0);
    chk("reset busy",      busy_u, 1'b0);
    chk("reset p_u",       p_u,    16'h0000);
    chk("reset p_s",       p_s,    16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed products in both modes.
    for (int i = 0; i < 7; i++) do_op(va[i], vb[i], veu[i], ves[i], $sformatf("vec%0d", i));

    // Backpressure with a new operand held at the input.
    out_ready = 1'b0;
    send(8'd9, 8'd9);
    wait_out(cyc);
    chk("bp latency", cyc, N + 1);
    @(posedge clk);
    #1;
    a = 8'd5;
    b = 8'd4;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp out_valid hold", ov_u, 1'b1);
      chk("bp p_u hold",       p_u,  16'h0051);
      chk("bp p_s hold",       p_s,  16'h0051);
      chk("bp in_ready low",   ir_u, 1'b0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp in_ready after hs",  ir_u, 1'b1);
    chk("bp out_valid after hs", ov_u, 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(cyc);
    chk("bp held op latency", cyc, N + 1);
    chk("bp held op p_u", p_u, 16'h0014);
    chk("bp held op p_s", p_s, 16'h0014);
    @(posedge clk);
    #1;

    // Abort during the cnt=3 cycle of RUN.
    send(8'd100, 8'd3);
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort in_ready", ir_u,   1'b1);
    chk("abort busy",     busy_s, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort no out_valid", ov_u | ov_s, 1'b0);
    end
    chk("abort p_u kept", p_u, 16'h0014);
    chk("abort p_s kept", p_s, 16'h0014);
    @(posedge clk);
    #1;
    do_op(8'd6, 8'd7, 16'h002A, 16'h002A, "after abort");

    // Asynchronous reset mid-RUN.
    send(8'd50, 8'd50);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst in_ready",  ir_u,   1'b1);
    chk("async rst busy",      busy_u, 1'b0);
    chk("async rst out_valid", ov_s,   1'b0);
    chk("async rst p_u",       p_u,    16'h0000);
    chk("async rst p_s",       p_s,    16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_op(8'd3, 8'd5, 16'h000F, 16'h000F, "after reset");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
